// File: rtl/ula_issue.sv
// Issue/writeback stage in front of the 16-bit ALU: decodes instruction words,
// reads the 8x16 register file with Res bypass and one-cycle stall, writes back Res.
module ula_issue #(
  parameter int NREGS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] InstrIn,
  input  logic        InstrValid,
  output logic        InstrReady,
  output logic [15:0] OpA,
  output logic [15:0] OpB,
  output logic [3:0]  Op,
  input  logic [15:0] Res,
  input  logic [2:0]  FlagReg,
  output logic [2:0]  Flags,
  output logic        IllegalInstr,
  output logic        Busy,
  input  logic [2:0]  DbgAddr,
  output logic [15:0] DbgData
);

  logic [15:0] regs [NREGS];

  logic       s1_valid;
  logic [2:0] s1_rd;
  logic       s2_valid;
  logic [2:0] s2_rd;

  logic [3:0] opcode;
  logic [2:0] rd;
  logic [2:0] rs;
  logic [2:0] rt;
  logic       is_alu;
  logic       is_li;
  logic       is_illegal;
  logic       stall;
  logic       accept;
  logic [15:0] next_a;
  logic [15:0] next_b;
  logic [3:0]  next_op;
  logic        unused_bits;

  assign opcode      = InstrIn[15:12];
  assign rd          = InstrIn[11:9];
  assign rs          = InstrIn[8:6];
  assign rt          = InstrIn[5:3];
  assign unused_bits = ^InstrIn[2:0];

  assign is_alu     = (opcode < 4'd6);
  assign is_li      = (opcode == 4'd6);
  assign is_illegal = (opcode > 4'd6);

  // A source still sitting in s1 has no result yet; one in s2 comes from Res.
  always_comb begin
    stall   = 1'b0;
    next_a  = '0;
    next_b  = '0;
    next_op = opcode;
    if (is_alu) begin
      if (s1_valid && ((s1_rd == rs) || (s1_rd == rt)))
        stall = 1'b1;
      next_a = (s2_valid && (s2_rd == rs)) ? Res : regs[rs];
      next_b = (s2_valid && (s2_rd == rt)) ? Res : regs[rt];
    end else if (is_li) begin
      next_a  = {{7{InstrIn[8]}}, InstrIn[8:0]};
      next_b  = '0;
      next_op = 4'd0;
    end
  end

  assign InstrReady = !RST && !stall;
  assign accept     = InstrValid && InstrReady;
  assign Busy       = s1_valid || s2_valid;
  assign DbgData    = regs[DbgAddr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      OpA          <= '0;
      OpB          <= '0;
      Op           <= '0;
      Flags        <= '0;
      IllegalInstr <= 1'b0;
      s1_valid     <= 1'b0;
      s1_rd        <= '0;
      s2_valid     <= 1'b0;
      s2_rd        <= '0;
    end else begin
      s2_valid     <= s1_valid;
      s2_rd        <= s1_rd;
      s1_valid     <= accept && !is_illegal;
      s1_rd        <= rd;
      IllegalInstr <= accept && is_illegal;
      if (accept && !is_illegal) begin
        OpA <= next_a;
        OpB <= next_b;
        Op  <= next_op;
      end
      // Res at this edge belongs to the instruction tracked in s2.
      if (s2_valid) begin
        regs[s2_rd] <= Res;
        Flags       <= FlagReg;
      end
    end
  end

endmodule

// File: tb/tb_ula_issue.sv
// Directed bench for ula_issue with a small registered ALU model driving Res/FlagReg.
module tb_ula_issue;

  logic        CLK;
  logic        RST;
  logic [15:0] InstrIn;
  logic        InstrValid;
  logic        InstrReady;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic [3:0]  Op;
  logic [15:0] Res;
  logic [2:0]  FlagReg;
  logic [2:0]  Flags;
  logic        IllegalInstr;
  logic        Busy;
  logic [2:0]  DbgAddr;
  logic [15:0] DbgData;

  int errors = 0;
  int checks = 0;

  ula_issue #(.NREGS(8)) dut (
    .CLK(CLK), .RST(RST), .InstrIn(InstrIn), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .OpA(OpA), .OpB(OpB), .Op(Op), .Res(Res),
    .FlagReg(FlagReg), .Flags(Flags), .IllegalInstr(IllegalInstr), .Busy(Busy),
    .DbgAddr(DbgAddr), .DbgData(DbgData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ALU stand-in: flags are [Z N C], C is carry for ADD and borrow for SUB.
  function automatic logic [18:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    logic [16:0] wide;
    logic [15:0] r;
    logic        c;
    wide = '0;
    r = '0;
    c = 1'b0;
    case (op)
      4'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[15:0]; c = wide[16]; end
      4'd1: begin r = a - b; c = (a < b); end
      4'd2: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      default: r = '0;
    endcase
    return {(r == 16'd0), r[15], c, r};
  endfunction

  always @(posedge CLK) begin
    logic [18:0] o;
    o = alu(OpA, OpB, Op);
    Res     <= o[15:0];
    FlagReg <= o[18:16];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    InstrValid = 1'b0;
    InstrIn = 16'h0000;
    tick();
    tick();
    checks++; if (InstrReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", InstrReady); end
    checks++; if (OpA !== 16'h0000) begin errors++; $display("[TB] FAIL reset_opa: got %h expected 0000", OpA); end
    checks++; if (OpB !== 16'h0000) begin errors++; $display("[TB] FAIL reset_opb: got %h expected 0000", OpB); end
    checks++; if (Op !== 4'h0) begin errors++; $display("[TB] FAIL reset_op: got %h expected 0", Op); end
    checks++; if (Flags !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", Flags); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (IllegalInstr !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %b expected 0", IllegalInstr); end
    for (int i = 0; i < 8; i++) begin
      DbgAddr = i[2:0];
      #1;
      checks++; if (DbgData !== 16'h0000) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h expected 0000", i, DbgData); end
    end
    RST = 1'b0;
    #1;
    checks++; if (InstrReady !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b expected 1", InstrReady); end
  endtask

  task automatic test_basic_sub();
    InstrIn = 16'h6205; InstrValid = 1'b1;
    tick();
    InstrValid = 1'b0;
    checks++; if (OpA !== 16'd5 || OpB !== 16'd0 || Op !== 4'd0) begin errors++; $display("[TB] FAIL li_r1_issue: got %h/%h/%h expected 0005/0000/0", OpA, OpB, Op); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("[TB] FAIL li_busy: got %b expected 1", Busy); end
    tick(); tick(); tick();
    DbgAddr = 3'd1; #1;
    checks++; if (DbgData !== 16'd5) begin errors++; $display("[TB] FAIL li_r1_value: got %h expected 0005", DbgData); end
    InstrIn = 16'h6403; InstrValid = 1'b1;
    tick();
    InstrValid = 1'b0;
    tick(); tick(); tick();
    InstrIn = 16'h1650; InstrValid = 1'b1;
    #1;
    checks++; if (InstrReady !== 1'b1) begin errors++; $display("[TB] FAIL sub_ready: got %b expected 1", InstrReady); end
    tick();
    InstrValid = 1'b0;
    checks++; if (OpA !== 16'd5 || OpB !== 16'd3 || Op !== 4'd1) begin errors++; $display("[TB] FAIL sub_issue: got %h/%h/%h expected 0005/0003/1", OpA, OpB, Op); end
    tick();
    DbgAddr = 3'd3; #1;
    checks++; if (DbgData !== 16'd0) begin errors++; $display("[TB] FAIL sub_r3_early: got %h expected 0000", DbgData); end
    tick();
    checks++; if (DbgData !== 16'd2) begin errors++; $display("[TB] FAIL sub_r3_value: got %h expected 0002", DbgData); end
    checks++; if (Flags !== 3'b000) begin errors++; $display("[TB] FAIL sub_flags: got %b expected 000", Flags); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL sub_busy_done: got %b expected 0", Busy); end
  endtask

  task automatic test_stall();
    InstrIn = 16'h6207; InstrValid = 1'b1;
    tick();
    InstrIn = 16'h0448;
    #1;
    checks++; if (InstrReady !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready_low: got %b expected 0", InstrReady); end
    tick();
    checks++; if (InstrReady !== 1'b1) begin errors++; $display("[TB] FAIL stall_ready_back: got %b expected 1", InstrReady); end
    checks++; if (OpA !== 16'd7 || OpB !== 16'd0 || Op !== 4'd0) begin errors++; $display("[TB] FAIL stall_hold_ops: got %h/%h/%h expected 0007/0000/0", OpA, OpB, Op); end
    tick();
    InstrValid = 1'b0;
    checks++; if (OpA !== 16'd7 || OpB !== 16'd7 || Op !== 4'd0) begin errors++; $display("[TB] FAIL stall_bypass_issue: got %h/%h/%h expected 0007/0007/0", OpA, OpB, Op); end
    tick(); tick();
    DbgAddr = 3'd2; #1;
    checks++; if (DbgData !== 16'd14) begin errors++; $display("[TB] FAIL stall_r2_value: got %h expected 000e", DbgData); end
    DbgAddr = 3'd1; #1;
    checks++; if (DbgData !== 16'd7) begin errors++; $display("[TB] FAIL stall_r1_value: got %h expected 0007", DbgData); end
    checks++; if (Flags !== 3'b000) begin errors++; $display("[TB] FAIL stall_flags: got %b expected 000", Flags); end
  endtask

  task automatic test_bypass_distance2();
    InstrIn = 16'h6209; InstrValid = 1'b1;
    tick();
    InstrIn = 16'h6800;
    #1;
    checks++; if (InstrReady !== 1'b1) begin errors++; $display("[TB] FAIL d2_li_ready: got %b expected 1", InstrReady); end
    tick();
    InstrIn = 16'h5448;
    #1;
    checks++; if (InstrReady !== 1'b1) begin errors++; $display("[TB] FAIL d2_xor_ready: got %b expected 1", InstrReady); end
    tick();
    InstrValid = 1'b0;
    checks++; if (OpA !== 16'd9 || OpB !== 16'd9 || Op !== 4'd5) begin errors++; $display("[TB] FAIL d2_xor_issue: got %h/%h/%h expected 0009/0009/5", OpA, OpB, Op); end
    tick(); tick();
    DbgAddr = 3'd2; #1;
    checks++; if (DbgData !== 16'd0) begin errors++; $display("[TB] FAIL d2_r2_value: got %h expected 0000", DbgData); end
    DbgAddr = 3'd1; #1;
    checks++; if (DbgData !== 16'd9) begin errors++; $display("[TB] FAIL d2_r1_value: got %h expected 0009", DbgData); end
    checks++; if (Flags !== 3'b100) begin errors++; $display("[TB] FAIL d2_flags: got %b expected 100", Flags); end
  endtask

  task automatic test_illegal();
    InstrIn = 16'hF000; InstrValid = 1'b1;
    #1;
    checks++; if (InstrReady !== 1'b1) begin errors++; $display("[TB] FAIL ill_ready: got %b expected 1", InstrReady); end
    tick();
    InstrValid = 1'b0;
    checks++; if (IllegalInstr !== 1'b1) begin errors++; $display("[TB] FAIL ill_pulse: got %b expected 1", IllegalInstr); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL ill_busy: got %b expected 0", Busy); end
    checks++; if (OpA !== 16'd9 || OpB !== 16'd9 || Op !== 4'd5) begin errors++; $display("[TB] FAIL ill_hold_ops: got %h/%h/%h expected 0009/0009/5", OpA, OpB, Op); end
    tick();
    checks++; if (IllegalInstr !== 1'b0) begin errors++; $display("[TB] FAIL ill_pulse_end: got %b expected 0", IllegalInstr); end
    tick();
    DbgAddr = 3'd0; #1;
    checks++; if (DbgData !== 16'd0) begin errors++; $display("[TB] FAIL ill_r0: got %h expected 0000", DbgData); end
    DbgAddr = 3'd1; #1;
    checks++; if (DbgData !== 16'd9) begin errors++; $display("[TB] FAIL ill_r1: got %h expected 0009", DbgData); end
  endtask

  task automatic test_reset_midop();
    InstrIn = 16'h6BFF; InstrValid = 1'b1;
    tick();
    InstrValid = 1'b0;
    RST = 1'b1;
    tick();
    checks++; if (Busy !== 1'b0 || InstrReady !== 1'b0 || OpA !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_state: got busy=%b ready=%b opa=%h expected 0/0/0000", Busy, InstrReady, OpA); end
    RST = 1'b0;
    tick(); tick();
    DbgAddr = 3'd5; #1;
    checks++; if (DbgData !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_r5: got %h expected 0000", DbgData); end
    checks++; if (Flags !== 3'b000) begin errors++; $display("[TB] FAIL midrst_flags: got %b expected 000", Flags); end
    InstrValid = 1'b1;
    tick();
    InstrValid = 1'b0;
    checks++; if (OpA !== 16'hFFFF || OpB !== 16'h0000) begin errors++; $display("[TB] FAIL li_neg_issue: got %h/%h expected ffff/0000", OpA, OpB); end
    tick(); tick();
    checks++; if (DbgData !== 16'hFFFF) begin errors++; $display("[TB] FAIL li_neg_r5: got %h expected ffff", DbgData); end
    checks++; if (Flags !== 3'b010) begin errors++; $display("[TB] FAIL li_neg_flags: got %b expected 010", Flags); end
  endtask

  task automatic test_back_to_back();
    InstrIn = 16'h67FE; InstrValid = 1'b1;
    tick();
    InstrIn = 16'h2CC0;
    #1;
    checks++; if (InstrReady !== 1'b0) begin errors++; $display("[TB] FAIL slt_stall: got %b expected 0", InstrReady); end
    tick();
    tick();
    InstrValid = 1'b0;
    checks++; if (OpA !== 16'hFFFE || OpB !== 16'h0000 || Op !== 4'd2) begin errors++; $display("[TB] FAIL slt_issue: got %h/%h/%h expected fffe/0000/2", OpA, OpB, Op); end
    tick(); tick();
    DbgAddr = 3'd6; #1;
    checks++; if (DbgData !== 16'd1) begin errors++; $display("[TB] FAIL slt_r6: got %h expected 0001", DbgData); end
    DbgAddr = 3'd3; #1;
    checks++; if (DbgData !== 16'hFFFE) begin errors++; $display("[TB] FAIL slt_r3: got %h expected fffe", DbgData); end
    checks++; if (Flags !== 3'b000) begin errors++; $display("[TB] FAIL slt_flags: got %b expected 000", Flags); end
  endtask

  initial begin
    RST = 1'b1;
    InstrIn = 16'h0000;
    InstrValid = 1'b0;
    DbgAddr = 3'd0;
    test_reset();
    test_basic_sub();
    test_stall();
    test_bypass_distance2();
    test_illegal();
    test_reset_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ula_issue.md
# ula_issue

Issue and writeback stage directly upstream of the 16-bit ALU. It accepts 16-bit instruction words over a valid/ready handshake and decodes them. It reads operands from an internal 8×16 register file and drives `OpA`/`OpB`/`Op` into the ALU. Two cycles later it writes the ALU's registered `Res` back to the destination register and latches `FlagReg`, resolving read-after-write hazards by bypass and a one-cycle stall.

## Interface
- `NREGS`, 8: register count; the address width is fixed at 3 bits.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `InstrIn`  in  16  instruction word.
- `InstrValid`  in  1  `InstrIn` is valid.
- `InstrReady`  out  1  stage accepts `InstrIn` at this edge.
- `OpA`, `OpB`  out  16 each  registered operands to the ALU.
- `Op`  out  4  registered ALU opcode.
- `Res`  in  16  ALU result, registered inside the ALU.
- `FlagReg`  in  3  ALU flags `[Z N C]`.
- `Flags`  out  3  flags latched at writeback.
- `IllegalInstr`  out  1  one-cycle pulse on acceptance of an undefined opcode.
- `Busy`  out  1  any instruction is in flight (s1 or s2 valid).
- `DbgAddr`  in  3  debug read address.
- `DbgData`  out  16  combinational read of the register file; no bypass.

## Operation
- Encoding: `[15:12]` opcode, `[11:9]` rd, `[8:6]` rs, `[5:3]` rt.
- Opcodes 0–5 (ADD, SUB, SLT, AND, OR, XOR) are passed unchanged to `Op`. `OpA` = R[rs], `OpB` = R[rt].
- Opcode 6 is LI. It issues as an ALU ADD with `OpA` = sign-extended `InstrIn[8:0]`, `OpB` = 0, destination rd. It has no register sources.
- Opcodes 7–15 are illegal. The word is consumed and `IllegalInstr` pulses for one cycle. Nothing enters the pipeline, and `OpA`/`OpB`/`Op` hold their values.
- Pipeline tracking registers:
  - s1 = {valid, rd}: the instruction whose operands are on `OpA`/`OpB` this cycle.
  - s2 = {valid, rd}: the instruction whose `Res` is valid this cycle.
- Each edge: s2 ← s1; s1 ← the accepted legal instruction, or invalid.
- Writeback: when s2 is valid, R[s2.rd] ← `Res` and `Flags` ← `FlagReg` at the edge. Otherwise both hold.
- Hazard resolution, per source field used (rs and rt for opcodes 0–5; none for LI):
  - If s1 is valid and s1.rd = source: stall. `InstrReady` = 0 for this cycle.
  - Else if s2 is valid and s2.rd = source: the operand is taken from `Res` (bypass).
  - Else the operand is read from the register file.
- `InstrReady` = !RST && !stall. It is combinational and independent of `InstrValid`.
- Idle cycles (no acceptance) leave `OpA`/`OpB`/`Op` unchanged. The ALU recomputes them, but s1 is invalid, so no writeback occurs.
- All arithmetic is done by the ALU. This block only sign-extends 9→16 bits for LI.

## Timing
- Reset, applied at an edge with RST = 1:
  - Every register-file entry becomes 0.
  - `OpA` = `OpB` = 0, `Op` = 0.
  - `Flags` = 000, `IllegalInstr` = 0.
  - s1 and s2 become invalid, so `Busy` = 0.
  - `InstrReady` = 0 while RST is high.
- Latency: an instruction accepted at edge E drives `OpA`/`OpB`/`Op` after E. The ALU registers `Res` at E+1, and R[rd] and `Flags` update at E+2. `DbgData` shows the new value after E+2.
- Back-to-back dependent instructions (distance 1) cost exactly one stall cycle. The dependent instruction is then accepted with its operand bypassed from `Res`.
- Distance-2 dependency: no stall, operand bypassed from `Res`. This covers the write and read to the same register at the same edge.
- Distance ≥3: normal register-file read.
- Both sources equal to the same pending rd: the single stall or bypass rule applies to both.
- Reset mid-operation: in-flight s1/s2 are discarded and no writeback occurs at the RST edge.
- Handshake: a word is consumed only at an edge with `InstrValid` && `InstrReady`. While stalled, the producer must hold `InstrIn` stable.

## Test plan
- Reset: RST = 1 for 2 cycles → `InstrReady` = 0, `OpA` = `OpB` = 0, `Flags` = 000, `DbgData` = 0 for all 8 addresses. After RST falls → `InstrReady` = 1.
- LI r1, 5; LI r2, 3; SUB r3, r1, r2, spaced ≥3 cycles apart → r3 = 2 two edges after SUB is accepted, `Flags` = 000.
- LI r1, 7 immediately followed by ADD r2, r1, r1 → `InstrReady` low for exactly one cycle, `OpA` = `OpB` = 7 on issue, r2 = 14.
- LI r1, 9; LI r4, 0; XOR r2, r1, r1, back-to-back → no stall, `OpA` = `OpB` = 9 via bypass, r2 = 0, `Flags` = 100.
- `InstrIn` = 16'hF000 → `IllegalInstr` high for one cycle, `InstrReady` stays 1, no register changes, `Busy` stays 0.
- LI r5, -1 accepted, then RST asserted on the next edge → r5 remains 0, `Flags` = 000. A subsequent LI r5, -1 without reset gives r5 = 16'hFFFF and `Flags` = 010.
